// File: rtl/onehot_rr_arbiter_pkg.sv
// Shared constants, output-slot state and the pointer rotation helper
// used by the one-hot round-robin arbiter and its pick logic.
package onehot_arb_pkg;

    localparam int ONEHOT_ARB_N     = 4;
    localparam int ONEHOT_ARB_W     = 8;
    localparam int ONEHOT_ARB_MAX_N = 16;
    localparam int ONEHOT_ARB_IDX_W = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    // Result bit k is v[(k + ptr) mod n]; bits at and above n read as zero.
    function automatic logic [ONEHOT_ARB_MAX_N-1:0] rotate_by_ptr(
        input logic [ONEHOT_ARB_MAX_N-1:0] v,
        input int unsigned                 ptr,
        input int unsigned                 n
    );
        logic [ONEHOT_ARB_MAX_N-1:0] r;
        r = '0;
        for (int unsigned k = 0; k < ONEHOT_ARB_MAX_N; k++) begin
            if (k < n) begin
                r[ONEHOT_ARB_IDX_W'(k)] = v[ONEHOT_ARB_IDX_W'((k + ptr) % n)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/onehot_rr_arbiter_pick.sv
// Combinational round-robin pick: rotates the requests so ptr sits at bit 0,
// isolates the lowest set bit, then rotates the one-hot result back.
module onehot_rr_pick
    import onehot_arb_pkg::*;
#(
    parameter int N  = ONEHOT_ARB_N,
    parameter int PW = (N > 1) ? $clog2(N) : 1
)(
    input  logic [N-1:0]  i_valid,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_sel,
    output logic          o_any_valid
);

    logic [ONEHOT_ARB_MAX_N-1:0] w_rot;
    logic [ONEHOT_ARB_MAX_N-1:0] w_first;
    logic [ONEHOT_ARB_MAX_N-1:0] w_sel_full;
    logic [31:0]                 w_back;

    assign w_rot      = rotate_by_ptr(ONEHOT_ARB_MAX_N'(i_valid), 32'(i_ptr), N);
    assign w_first    = w_rot & (-w_rot);
    assign w_back     = 32'((N - int'(i_ptr)) % N);
    assign w_sel_full = rotate_by_ptr(w_first, w_back, N);

    assign o_sel       = w_sel_full[N-1:0];
    assign o_any_valid = |i_valid;

    if (N < ONEHOT_ARB_MAX_N) begin : g_pad
        logic w_unused_hi;
        assign w_unused_hi = |w_sel_full[ONEHOT_ARB_MAX_N-1:N];
    end

endmodule

// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter with a one-hot AND-OR data mux and a single registered
// output slot. Define ONEHOT_ARB_LOCK_EN to hold the grant across bursts (in_last).
module onehot_rr_arbiter
    import onehot_arb_pkg::*;
#(
    parameter int N = ONEHOT_ARB_N,
    parameter int W = ONEHOT_ARB_W
)(
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_last,
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [N-1:0]   out_grant,
    input  logic           out_ready
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    slot_state_t   r_state;
    slot_state_t   w_state_nxt;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptr_nxt;
    logic [W-1:0]  r_out_data;
    logic [N-1:0]  r_out_grant;

    logic [N-1:0]  w_pick_sel;
    logic          w_pick_any;
    logic [N-1:0]  w_sel;
    logic          w_any;
    logic          w_can_load;
    logic          w_take;
    logic          w_out_xfer;
    logic          w_advance;
    logic [W-1:0]  w_mux_data;
    logic [PW-1:0] w_idx;

    onehot_rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .i_valid     (in_valid),
        .i_ptr       (r_ptr),
        .o_sel       (w_pick_sel),
        .o_any_valid (w_pick_any)
    );

`ifdef ONEHOT_ARB_LOCK_EN
    // While locked the owner is the requester in the slot, i.e. r_out_grant.
    logic r_lock;
    logic w_last;

    assign w_sel     = r_lock ? (r_out_grant & in_valid) : w_pick_sel;
    assign w_any     = r_lock ? |(r_out_grant & in_valid) : w_pick_any;
    assign w_last    = |(in_ready & in_last);
    assign w_advance = w_take & w_last;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_lock <= 1'b0;
        end else if (w_take) begin
            r_lock <= ~w_last;
        end
    end
`else
    logic w_unused_last;

    assign w_unused_last = ^in_last;
    assign w_sel         = w_pick_sel;
    assign w_any         = w_pick_any;
    assign w_advance     = w_take;
`endif

    assign out_valid  = (r_state == FULL);
    assign w_out_xfer = out_valid & out_ready;
    assign w_can_load = ~out_valid | out_ready;
    assign in_ready   = (reset && w_can_load && w_any) ? w_sel : '0;
    assign w_take     = |in_ready;

    always_comb begin
        w_mux_data = '0;
        w_idx      = '0;
        for (int i = 0; i < N; i++) begin
            w_mux_data = w_mux_data | (in_data[i*W +: W] & {W{in_ready[i]}});
            if (in_ready[i]) begin
                w_idx = w_idx | PW'(i);
            end
        end
    end

    assign w_ptr_nxt = (int'(w_idx) == N - 1) ? '0 : w_idx + PW'(1);

    always_comb begin
        w_state_nxt = r_state;
        if (w_take) begin
            w_state_nxt = FULL;
        end else if (w_out_xfer) begin
            w_state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_out_data  <= '0;
            r_out_grant <= '0;
            r_ptr       <= '0;
        end else begin
            if (w_take) begin
                r_out_data  <= w_mux_data;
                r_out_grant <= in_ready;
            end
            if (w_advance) begin
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_grant = r_out_grant;

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Scoreboard bench for onehot_rr_arbiter: directed scenarios then random traffic,
// expected beats queued at accept time and checked when the DUT presents them.
module tb_onehot_rr_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] d;
        logic [N-1:0] g;
    } beat_t;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   in_valid = '0;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_last = '0;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [N-1:0]   out_grant;
    logic           out_ready = 1'b0;

    int    n_tests = 0;
    int    n_fail  = 0;
    beat_t q_exp[$];
    int    m_ptr   = 0;
    int    m_owner = 0;
    bit    m_lock  = 1'b0;

    localparam logic [N*W-1:0] CONT_DATA = {8'hF5, 8'hF9, 8'hFB, 8'hFD};

    onehot_rr_arbiter #(.N(N), .W(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_grant (out_grant),
        .out_ready (out_ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: scan requesters from ptr upward, the first valid one wins.
    task automatic model_step();
        logic [N-1:0] exp_rdy;
        int           sel;
        bit           can_load;
        beat_t        b;
        exp_rdy = '0;
        sel     = -1;
        if (!reset) begin
            q_exp.delete();
            m_ptr  = 0;
            m_lock = 1'b0;
        end else begin
            can_load = (q_exp.size() == 0) || out_ready;
            if (m_lock) begin
                if (in_valid[m_owner]) sel = m_owner;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (sel < 0 && in_valid[(m_ptr + k) % N]) sel = (m_ptr + k) % N;
                end
            end
            if (can_load && sel >= 0) begin
                exp_rdy[sel] = 1'b1;
                b.d = in_data[sel*W +: W];
                b.g = '0;
                b.g[sel] = 1'b1;
                q_exp.push_back(b);
`ifdef ONEHOT_ARB_LOCK_EN
                m_lock  = !in_last[sel];
                m_owner = sel;
                if (in_last[sel]) m_ptr = (sel + 1) % N;
`else
                m_ptr = (sel + 1) % N;
`endif
            end
        end
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
    endtask

    task automatic step(input logic rst, input logic [N-1:0] v, input logic [N*W-1:0] d,
                        input logic [N-1:0] l, input logic ordy);
        @(negedge clock);
        reset     = rst;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = ordy;
        #1;
        model_step();
    endtask

    // Monitor: compare the presented beat after each edge, retire it on an output transfer.
    initial begin
        forever begin
            @(posedge clock);
            #2;
            check("out_valid", 32'(out_valid), 32'(q_exp.size() != 0));
            if (out_valid && q_exp.size() != 0) begin
                check("out_data", 32'(out_data), 32'(q_exp[0].d));
                check("out_grant", 32'(out_grant), 32'(q_exp[0].g));
            end
            @(negedge clock);
            #3;
            if (reset && out_valid && out_ready && q_exp.size() != 0) begin
                void'(q_exp.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with all requesters active, then release: requester 0 first.
        repeat (3) step(1'b0, 4'b1111, CONT_DATA, 4'b1111, 1'b1);
        step(1'b1, 4'b1111, CONT_DATA, 4'b1111, 1'b1);
        // Single request from requester 2.
        step(1'b1, 4'b0100, {8'h00, 8'hF9, 8'h00, 8'h00}, 4'b1111, 1'b1);
        step(1'b1, 4'b0000, '0, 4'b1111, 1'b1);
        // Wrap-around from ptr=3.
        step(1'b1, 4'b1001, {8'hA3, 8'h00, 8'h00, 8'hA0}, 4'b1111, 1'b1);
        // Full contention, back-to-back.
        repeat (8) step(1'b1, 4'b1111, CONT_DATA, 4'b1111, 1'b1);
        repeat (2) step(1'b1, 4'b1111, CONT_DATA, 4'b1111, 1'b1);
        // Backpressure then release with same-cycle reload.
        repeat (5) step(1'b1, 4'b1111, CONT_DATA, 4'b1111, 1'b0);
        repeat (2) step(1'b1, 4'b1111, CONT_DATA, 4'b1111, 1'b1);
        // Reset while a beat is held: the beat is dropped.
        step(1'b1, 4'b1111, CONT_DATA, 4'b1111, 1'b0);
        step(1'b0, 4'b1111, CONT_DATA, 4'b1111, 1'b1);
        repeat (2) step(1'b1, 4'b0000, '0, 4'b1111, 1'b1);
        // Burst from requester 1 (last on its third beat) amid full contention.
        step(1'b1, 4'b0001, CONT_DATA, 4'b1111, 1'b1);
        repeat (2) step(1'b1, 4'b1111, CONT_DATA, 4'b1101, 1'b1);
        step(1'b1, 4'b1111, CONT_DATA, 4'b1111, 1'b1);
        repeat (2) step(1'b1, 4'b1111, CONT_DATA, 4'b1111, 1'b1);
        // Random traffic.
        for (int c = 0; c < 300; c++) begin
            step(1'b1, N'($urandom), $urandom, N'($urandom),
                 ($urandom_range(0, 3) != 0));
        end
        // Drain any open lock and the held beat.
        repeat (6) step(1'b1, 4'b0000, '0, 4'b1111, 1'b1);
        repeat (2) step(1'b1, 4'b1111, $urandom, 4'b1111, 1'b1);
        repeat (3) step(1'b1, 4'b0000, '0, 4'b1111, 1'b1);
        @(posedge clock);
        #4;
        check("drain_empty", 32'(q_exp.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
